gf180_ram_arbiter: RTL and testbench
====================================

Name: gf180_ram_arbiter

Overview:
Two-port arbiter and sequencer in front of one 64x8 gf180 SRAM macro wrapper (active-low CEN/GWEN/WEN, synchronous read). After reset it clears the whole array to a fixed value. It then shares the single macro port between two requesters (port 0 = CPU, port 1 = tile fetch) using a valid/ready handshake and round-robin arbitration. It returns read data one cycle after acceptance and translates active-high write masks into the macro's active-low controls.

Parameters:
ADDR_W, 6, macro address width (depth 2^ADDR_W = 64)
DATA_W, 8, data and mask width
INIT_EN, 1, 1 = clear array after reset; 0 = enter RUN directly
INIT_VALUE, 8'h00, value written to every word during INIT

Ports:
CLK  in  1  clock; all state changes on rising edge
RESETN  in  1  synchronous active-low reset
init_done  out  1  high once array clear is complete (high in RUN)
p0_req_valid  in  1  port 0 request
p0_req_ready  out  1  port 0 granted this cycle
p0_we  in  1  1 = write, 0 = read
p0_addr  in  ADDR_W  word address
p0_wdata  in  DATA_W  write data
p0_wmask  in  DATA_W  active-high per-bit write enable
p0_rvalid  out  1  read data valid pulse
p0_rdata  out  DATA_W  read data
p1_*  same set and widths as p0_*, for port 1
ram_cen  out  1  macro CEN, active-low
ram_gwen  out  1  macro GWEN, active-low
ram_wen  out  DATA_W  macro WEN, active-low per bit
ram_a  out  ADDR_W  macro address
ram_d  out  DATA_W  macro write data
ram_q  in  DATA_W  macro read data

Behaviour:
- Clocking: single clock CLK; synchronous active-low reset RESETN.
- Reset (RESETN=0, sampled on CLK):
  - init_done=0; pX_req_ready=0; pX_rvalid=0; pX_rdata=0.
  - ram_cen=1, ram_gwen=1, ram_wen=all 1, ram_a=0, ram_d=0.
  - RR pointer set so port 0 wins the first contest; init counter=0.
- States: INIT, RUN. Exit from reset goes to INIT if INIT_EN=1, otherwise to RUN.
- INIT:
  - Each cycle drive cen=0, gwen=0, wen=0, a=counter, d=INIT_VALUE; counter increments.
  - After the write of address 63, go to RUN on the next edge.
  - 64 write cycles; init_done rises in cycle 65 after reset release.
  - Both readies stay 0 throughout; requests are ignored, not queued.
- RUN:
  - init_done=1.
  - Grant is combinational from the valids:
    - only one valid: that port is granted;
    - both valid: the port not granted last time is granted.
  - pX_req_ready = grant to port X.
  - The RR pointer updates to the granted port on every grant.
  - Requesters must not make valid depend on ready.
  - Handshake occurs when valid and ready are both 1. Request fields must be stable while valid=1 and ready=0.
- Macro drive for a granted request (same cycle, combinational):
  - a=addr, d=wdata, cen=0.
  - Write: gwen=0, wen=~wmask.
  - Read: gwen=1, wen=all 1.
- Macro drive with no grant: cen=1, gwen=1, wen=all 1; a and d hold their last values.
- Read latency:
  - A read accepted at edge N gives pX_rvalid=1 for exactly the following cycle.
  - In that cycle pX_rdata=ram_q, and the value is also captured into a hold register.
  - Outside rvalid cycles, pX_rdata shows the held value of its own port.
  - Writes produce no rvalid.
- Throughput: one access per cycle in total. An uncontested port may issue back-to-back every cycle.
- Hazards:
  - Write then read of the same address on the next cycle returns the new data.
  - Read and a write to the same address on the following cycle: the read returns old data.
- Masks:
  - wmask=0 performs a write cycle that changes no bits.
  - wmask=FF is a full write.
- Reset mid-operation:
  - Reset during INIT restarts the clear from address 0.
  - Reset in RUN drops any pending rvalid, with no pulse after reset.

Test Plan:
- Reset then 70 cycles with INIT_EN=1 -> ram_a walks 0..63 with cen=0, gwen=0, wen=00, d=00; init_done=1 from cycle 65; readies 0 before that.
- Port 0 writes addr 5 = 8'hA5 (mask FF), next cycle reads addr 5 -> p0_rvalid one cycle later with p0_rdata=A5; p1_rvalid stays 0.
- Both ports hold valid reads (p0 addr 1, p1 addr 2) for 4 cycles after INIT -> grants alternate p0, p1, p0, p1; each port gets rvalid with its own data.
- Partial write: word=8'hFF, then write 8'h00 with wmask=8'h0F -> ram_wen=F0; readback=F0.
- Assert RESETN=0 at INIT counter 30 for one cycle -> clear restarts at address 0; init_done rises 64 cycles after release.
- Port 1 read accepted, RESETN=0 on the next edge -> no p1_rvalid pulse; p1_rdata=0 after reset.

Source files
------------

// File: rtl/gf180_ram_arbiter_if.sv
// One requester port of the gf180 RAM arbiter: valid/ready request plus read-return.
interface gf180_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] wmask;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, we, addr, wdata, wmask,
        input  req_ready, rvalid, rdata
    );

    modport slave (
        input  req_valid, we, addr, wdata, wmask,
        output req_ready, rvalid, rdata
    );
endinterface

// File: rtl/gf180_ram_arbiter.sv
// Clears a gf180 SRAM macro after reset, then round-robin shares its single
// port between two requesters with one-cycle read return.
module gf180_ram_arbiter #(
    parameter int unsigned        ADDR_W     = 6,
    parameter int unsigned        DATA_W     = 8,
    parameter bit                 INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              CLK,
    input  logic              RESETN,
    output logic              init_done,
    gf180_ram_arbiter_if.slave p0,
    gf180_ram_arbiter_if.slave p1,
    output logic              ram_cen,
    output logic              ram_gwen,
    output logic [DATA_W-1:0] ram_wen,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_p1_q, last_p1_d;   // 1 when port 1 took the previous grant
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_W-1:0] hold0_q, hold1_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q   <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_q     <= '0;
            last_p1_q <= 1'b1;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
            a_q       <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_p1_q <= last_p1_d;
            rv0_q     <= rv0_d;
            rv1_q     <= rv1_d;
            a_q       <= ram_a;
            d_q       <= ram_d;
            if (rv0_q) hold0_q <= ram_q;
            if (rv1_q) hold1_q <= ram_q;
        end
    end

    // Outputs idle while reset is held so nothing reaches the macro or requesters.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_p1_d    = last_p1_q;
        rv0_d        = 1'b0;
        rv1_d        = 1'b0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        init_done    = 1'b0;
        p0.req_ready = 1'b0;
        p1.req_ready = 1'b0;
        ram_cen      = 1'b1;
        ram_gwen     = 1'b1;
        ram_wen      = '1;
        ram_a        = a_q;
        ram_d        = d_q;
        if (RESETN) begin
            case (state_q)
                ST_INIT: begin
                    ram_cen  = 1'b0;
                    ram_gwen = 1'b0;
                    ram_wen  = '0;
                    ram_a    = cnt_q;
                    ram_d    = INIT_VALUE;
                    cnt_d    = ADDR_W'(cnt_q + 1'b1);
                    if (cnt_q == LAST_ADDR) state_d = ST_RUN;
                end
                ST_RUN: begin
                    init_done    = 1'b1;
                    gnt0         = p0.req_valid & (~p1.req_valid | last_p1_q);
                    gnt1         = p1.req_valid & (~p0.req_valid | ~last_p1_q);
                    p0.req_ready = gnt0;
                    p1.req_ready = gnt1;
                    if (gnt0) begin
                        ram_cen   = 1'b0;
                        ram_gwen  = ~p0.we;
                        ram_wen   = p0.we ? ~p0.wmask : '1;
                        ram_a     = p0.addr;
                        ram_d     = p0.wdata;
                        last_p1_d = 1'b0;
                        rv0_d     = ~p0.we;
                    end else if (gnt1) begin
                        ram_cen   = 1'b0;
                        ram_gwen  = ~p1.we;
                        ram_wen   = p1.we ? ~p1.wmask : '1;
                        ram_a     = p1.addr;
                        ram_d     = p1.wdata;
                        last_p1_d = 1'b1;
                        rv1_d     = ~p1.we;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // A pending read pulse is suppressed as soon as reset is asserted.
    assign rvalid0   = rv0_q & RESETN;
    assign rvalid1   = rv1_q & RESETN;
    assign p0.rvalid = rvalid0;
    assign p1.rvalid = rvalid1;
    assign p0.rdata  = rvalid0 ? ram_q : hold0_q;
    assign p1.rdata  = rvalid1 ? ram_q : hold1_q;
endmodule

// File: tb/tb_gf180_ram_arbiter.sv
// Bench for gf180_ram_arbiter: SRAM macro model, vector table, random traffic
// against a reference model, and reset corner sequences.
`timescale 1ns/1ps
module tb_gf180_ram_arbiter;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned NVEC   = 18;

    logic              CLK = 1'b0;
    logic              RESETN;
    logic              init_done;
    logic              ram_cen, ram_gwen;
    logic [DATA_W-1:0] ram_wen, ram_d, ram_q;
    logic [ADDR_W-1:0] ram_a;

    gf180_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0 ();
    gf180_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1 ();

    gf180_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_EN(1'b1), .INIT_VALUE(8'h00)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .init_done(init_done),
        .p0(p0), .p1(p1),
        .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
        .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 CLK = ~CLK;

    // Behavioural gf180 macro: active-low controls, synchronous read.
    logic [DATA_W-1:0] macro_mem [DEPTH];
    logic              scramble;
    always @(posedge CLK) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) macro_mem[i] <= DATA_W'($urandom);
            ram_q <= 8'h5A;
        end else if (!ram_cen) begin
            if (!ram_gwen) macro_mem[ram_a] <= (macro_mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
            else           ram_q <= macro_mem[ram_a];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
        end
    endtask

    // Reference model: memory contents, last winner, per-port read return.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              m_last;
    logic              m_pend  [2];
    logic [DATA_W-1:0] m_pdata [2];
    logic [DATA_W-1:0] m_hold  [2];
    logic              g0, g1;

    task automatic model_grant();
        g0 = 1'b0;
        g1 = 1'b0;
        if (p0.req_valid && p1.req_valid) begin
            if (m_last) g0 = 1'b1;
            else        g1 = 1'b1;
        end else if (p0.req_valid) g0 = 1'b1;
        else if (p1.req_valid)     g1 = 1'b1;
    endtask

    task automatic model_access(input int p, input logic we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        if (we) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        else begin
            m_pend[p]  = 1'b1;
            m_pdata[p] = ref_mem[a];
        end
    endtask

    task automatic model_commit();
        for (int p = 0; p < 2; p++) begin
            if (m_pend[p]) m_hold[p] = m_pdata[p];
            m_pend[p] = 1'b0;
        end
        if (g0) begin
            model_access(0, p0.we, p0.addr, p0.wdata, p0.wmask);
            m_last = 1'b0;
        end
        if (g1) begin
            model_access(1, p1.we, p1.addr, p1.wdata, p1.wmask);
            m_last = 1'b1;
        end
    endtask

    typedef struct packed {
        logic v0; logic we0; logic [5:0] a0; logic [7:0] wd0; logic [7:0] wm0;
        logic v1; logic we1; logic [5:0] a1; logic [7:0] wd1; logic [7:0] wm1;
        logic [1:0] rdy; logic cen; logic gwen; logic [7:0] wen; logic [5:0] a; logic [7:0] d;
        logic [1:0] rv; logic [7:0] rd0; logic [7:0] rd1;
    } vec_t;
    vec_t vecs [NVEC];

    task automatic apply(input vec_t v);
        p0.req_valid = v.v0; p0.we = v.we0; p0.addr = v.a0; p0.wdata = v.wd0; p0.wmask = v.wm0;
        p1.req_valid = v.v1; p1.we = v.we1; p1.addr = v.a1; p1.wdata = v.wd1; p1.wmask = v.wm1;
    endtask

    task automatic idle_ports();
        p0.req_valid = 1'b0; p0.we = 1'b0; p0.addr = '0; p0.wdata = '0; p0.wmask = '0;
        p1.req_valid = 1'b0; p1.we = 1'b0; p1.addr = '0; p1.wdata = '0; p1.wmask = '0;
    endtask

    task automatic p1_req(input logic we, input logic [5:0] a, input logic [7:0] d);
        p1.req_valid = 1'b1; p1.we = we; p1.addr = a; p1.wdata = d; p1.wmask = 8'hFF;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic hold_p0, hold_p1;
        //               v0 we0  a0    wd0    wm0    v1 we1  a1    wd1    wm1    rdy  cen  gwen wen    a     d      rv   rd0    rd1
        vecs[0]  = '{1'b1,1'b1,6'd5,8'hA5,8'hFF, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b10,1'b0,1'b0,8'h00,6'd5,8'hA5, 2'b00,8'h00,8'h00};
        vecs[1]  = '{1'b1,1'b0,6'd5,8'h00,8'h00, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b10,1'b0,1'b1,8'hFF,6'd5,8'h00, 2'b00,8'h00,8'h00};
        vecs[2]  = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b00,1'b1,1'b1,8'hFF,6'd5,8'h00, 2'b10,8'hA5,8'h00};
        vecs[3]  = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b1,1'b1,6'd2,8'h3C,8'hFF, 2'b01,1'b0,1'b0,8'h00,6'd2,8'h3C, 2'b00,8'hA5,8'h00};
        vecs[4]  = '{1'b1,1'b1,6'd1,8'hC3,8'hFF, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b10,1'b0,1'b0,8'h00,6'd1,8'hC3, 2'b00,8'hA5,8'h00};
        vecs[5]  = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b1,1'b1,6'd7,8'hFF,8'hFF, 2'b01,1'b0,1'b0,8'h00,6'd7,8'hFF, 2'b00,8'hA5,8'h00};
        vecs[6]  = '{1'b1,1'b0,6'd1,8'h00,8'h00, 1'b1,1'b0,6'd2,8'h00,8'h00, 2'b10,1'b0,1'b1,8'hFF,6'd1,8'h00, 2'b00,8'hA5,8'h00};
        vecs[7]  = '{1'b1,1'b0,6'd1,8'h00,8'h00, 1'b1,1'b0,6'd2,8'h00,8'h00, 2'b01,1'b0,1'b1,8'hFF,6'd2,8'h00, 2'b10,8'hC3,8'h00};
        vecs[8]  = '{1'b1,1'b0,6'd1,8'h00,8'h00, 1'b1,1'b0,6'd2,8'h00,8'h00, 2'b10,1'b0,1'b1,8'hFF,6'd1,8'h00, 2'b01,8'hC3,8'h3C};
        vecs[9]  = '{1'b1,1'b0,6'd1,8'h00,8'h00, 1'b1,1'b0,6'd2,8'h00,8'h00, 2'b01,1'b0,1'b1,8'hFF,6'd2,8'h00, 2'b10,8'hC3,8'h3C};
        vecs[10] = '{1'b1,1'b1,6'd7,8'h00,8'h0F, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b10,1'b0,1'b0,8'hF0,6'd7,8'h00, 2'b01,8'hC3,8'h3C};
        vecs[11] = '{1'b1,1'b0,6'd7,8'h00,8'h00, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b10,1'b0,1'b1,8'hFF,6'd7,8'h00, 2'b00,8'hC3,8'h3C};
        vecs[12] = '{1'b1,1'b1,6'd7,8'h55,8'h00, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b10,1'b0,1'b0,8'hFF,6'd7,8'h55, 2'b10,8'hF0,8'h3C};
        vecs[13] = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b1,1'b0,6'd7,8'h00,8'h00, 2'b01,1'b0,1'b1,8'hFF,6'd7,8'h00, 2'b00,8'hF0,8'h3C};
        vecs[14] = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b00,1'b1,1'b1,8'hFF,6'd7,8'h00, 2'b01,8'hF0,8'hF0};
        vecs[15] = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b1,1'b0,6'd0,8'h00,8'h00, 2'b01,1'b0,1'b1,8'hFF,6'd0,8'h00, 2'b00,8'hF0,8'hF0};
        vecs[16] = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b1,1'b0,6'd0,8'h00,8'h00, 2'b01,1'b0,1'b1,8'hFF,6'd0,8'h00, 2'b01,8'hF0,8'h00};
        vecs[17] = '{1'b0,1'b0,6'd0,8'h00,8'h00, 1'b0,1'b0,6'd0,8'h00,8'h00, 2'b00,1'b1,1'b1,8'hFF,6'd0,8'h00, 2'b01,8'hF0,8'h00};

        // Reset with garbage in the macro
        RESETN   = 1'b0;
        scramble = 1'b1;
        idle_ports();
        @(posedge CLK); #1;
        scramble = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("reset.status", 0, 64'({init_done, p0.req_ready, p1.req_ready, p0.rvalid, p1.rvalid}), 64'(0));
        check("reset.ram", 0, 64'({ram_cen, ram_gwen, ram_wen, ram_a, ram_d}), 64'({1'b1, 1'b1, 8'hFF, 6'd0, 8'h00}));
        check("reset.rdata", 0, 64'({p0.rdata, p1.rdata}), 64'(0));

        // INIT walk; requests during INIT must be ignored
        @(posedge CLK); #1;
        RESETN = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            p0.req_valid = (c <= 64);
            p1.req_valid = (c <= 64);
            @(negedge CLK);
            if (c <= 64)
                check("init.walk", c, 64'({init_done, p0.req_ready, p1.req_ready, ram_cen, ram_gwen, ram_wen, ram_a, ram_d}),
                      64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'(c - 1), 8'h00}));
            else
                check("init.done", c, 64'({init_done, p0.req_ready, p1.req_ready, ram_cen, ram_gwen, ram_wen, ram_a, ram_d}),
                      64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 6'd63, 8'h00}));
            @(posedge CLK); #1;
        end

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        m_last = 1'b1;
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 1'b0; m_pdata[p] = '0; m_hold[p] = '0;
        end

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            @(negedge CLK);
            check("vec.ready", i, 64'({p0.req_ready, p1.req_ready}), 64'(vecs[i].rdy));
            check("vec.ram", i, 64'({ram_cen, ram_gwen, ram_wen, ram_a, ram_d}),
                  64'({vecs[i].cen, vecs[i].gwen, vecs[i].wen, vecs[i].a, vecs[i].d}));
            check("vec.rvalid", i, 64'({p0.rvalid, p1.rvalid}), 64'(vecs[i].rv));
            check("vec.rdata", i, 64'({p0.rdata, p1.rdata}), 64'({vecs[i].rd0, vecs[i].rd1}));
            model_grant();
            model_commit();
            @(posedge CLK); #1;
        end

        // Random traffic; a request waiting for ready keeps its fields
        hold_p0 = 1'b0;
        hold_p1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!hold_p0) begin
                p0.req_valid = ($urandom_range(0, 2) != 0);
                p0.we        = 1'($urandom);
                p0.addr      = 6'($urandom_range(0, 15));
                p0.wdata     = 8'($urandom);
                p0.wmask     = ($urandom_range(0, 3) == 0) ? 8'h00 : (($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
            end
            if (!hold_p1) begin
                p1.req_valid = ($urandom_range(0, 2) != 0);
                p1.we        = 1'($urandom);
                p1.addr      = 6'($urandom_range(0, 15));
                p1.wdata     = 8'($urandom);
                p1.wmask     = ($urandom_range(0, 3) == 0) ? 8'h00 : (($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
            end
            @(negedge CLK);
            model_grant();
            check("rnd.ready", c, 64'({p0.req_ready, p1.req_ready}), 64'({g0, g1}));
            check("rnd.rvalid", c, 64'({p0.rvalid, p1.rvalid}), 64'({m_pend[0], m_pend[1]}));
            check("rnd.rdata", c, 64'({p0.rdata, p1.rdata}),
                  64'({m_pend[0] ? m_pdata[0] : m_hold[0], m_pend[1] ? m_pdata[1] : m_hold[1]}));
            if (g0)
                check("rnd.ram0", c, 64'({ram_cen, ram_gwen, ram_wen, ram_a, ram_d}),
                      64'({1'b0, ~p0.we, p0.we ? ~p0.wmask : 8'hFF, p0.addr, p0.wdata}));
            else if (g1)
                check("rnd.ram1", c, 64'({ram_cen, ram_gwen, ram_wen, ram_a, ram_d}),
                      64'({1'b0, ~p1.we, p1.we ? ~p1.wmask : 8'hFF, p1.addr, p1.wdata}));
            else
                check("rnd.idle", c, 64'({ram_cen, ram_gwen, ram_wen}), 64'({1'b1, 1'b1, 8'hFF}));
            hold_p0 = p0.req_valid && !g0;
            hold_p1 = p1.req_valid && !g1;
            model_commit();
            @(posedge CLK); #1;
        end

        // Reset while a port-1 read is in flight
        idle_ports();
        @(posedge CLK); #1;
        p1_req(1'b1, 6'd3, 8'h9A);
        @(negedge CLK);
        check("rstrun.wr_ready", 0, 64'(p1.req_ready), 64'(1));
        @(posedge CLK); #1;
        p1_req(1'b0, 6'd3, 8'h00);
        @(posedge CLK); #1;
        p1.req_valid = 1'b0;
        @(negedge CLK);
        check("rstrun.first_read", 0, 64'({p1.rvalid, p1.rdata}), 64'({1'b1, 8'h9A}));
        @(posedge CLK); #1;
        p1_req(1'b0, 6'd3, 8'h00);
        @(negedge CLK);
        check("rstrun.rd_ready", 0, 64'(p1.req_ready), 64'(1));
        @(posedge CLK); #1;
        RESETN = 1'b0;
        p1.req_valid = 1'b0;
        @(negedge CLK);
        check("rstrun.no_pulse", 0, 64'(p1.rvalid), 64'(0));
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rstrun.after", 0, 64'({p1.rvalid, p1.rdata, init_done, ram_cen}), 64'({1'b0, 8'h00, 1'b0, 1'b1}));

        // INIT restarted by a reset at counter 30
        @(posedge CLK); #1;
        RESETN = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            check("initrst.walk", c, 64'({p1.rvalid, ram_cen, ram_a}), 64'({1'b0, 1'b0, 6'(c - 1)}));
            @(posedge CLK); #1;
        end
        RESETN = 1'b0;
        @(negedge CLK);
        check("initrst.held", 0, 64'({init_done, ram_cen}), 64'({1'b0, 1'b1}));
        @(posedge CLK); #1;
        RESETN = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            @(negedge CLK);
            if (c <= 64)
                check("initrst.rewalk", c, 64'({init_done, ram_cen, ram_gwen, ram_a}), 64'({1'b0, 1'b0, 1'b0, 6'(c - 1)}));
            else
                check("initrst.done", c, 64'({init_done, ram_cen}), 64'({1'b1, 1'b1}));
            @(posedge CLK); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
